// File: rtl/code_pkg.sv
`default_nettype none
// code_pkg: state encoding and width helpers shared by the frame sequencer and the code generator.
package code_pkg;

  localparam int WORD_W_DEF = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_piso.sv
`default_nettype none
// code_piso: parallel-load, shift-left serializer; the MSB is the current serial bit.
module code_piso #(
  parameter int WORD_W = code_pkg::WORD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              msb_o
);

  logic [WORD_W-1:0] sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= data_i;
    end else if (shift_i) begin
      sh_q <= {sh_q[WORD_W-2:0], 1'b0};
    end
  end

  assign msb_o = sh_q[WORD_W-1];

endmodule
`default_nettype wire

// File: rtl/code_frame_sequencer.sv
`default_nettype none
// code_frame_sequencer: drives the dual-output code generator and streams BURST_LEN
// captured code words MSB-first over a valid/ready bit interface.
module code_frame_sequencer
  import code_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int BURST_LEN = 4,
  parameter int GAP_CYC   = 2,
  parameter int GEN_LAT   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Slt_req,
  input  logic [WORD_W-1:0] Code0,
  input  logic [WORD_W-1:0] Code1,
  output logic              Gen_en,
  output logic              Gen_slt,
  output logic              Bit_out,
  output logic              Bit_valid,
  input  logic              Bit_ready,
  output logic              Frame_sof,
  output logic              Frame_eof,
  output logic              Busy,
  output logic              Done
);

  localparam int BIT_W   = cnt_w(WORD_W);
  localparam int WRD_W   = cnt_w(BURST_LEN);
  localparam int DLY_MAX = (GEN_LAT > GAP_CYC) ? GEN_LAT : GAP_CYC;
  localparam int DLY_W   = cnt_w(DLY_MAX);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(BURST_LEN - 1);
  localparam logic [DLY_W-1:0] LAT_LAST = DLY_W'(GEN_LAT - 1);
  localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_e           state_q, state_d;
  logic             slt_q, slt_d;
  logic [WRD_W-1:0] word_q, word_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             load, shift, msb;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      slt_q   <= 1'b0;
      word_q  <= '0;
      bit_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      slt_q   <= slt_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slt_d   = slt_q;
    word_d  = word_q;
    bit_d   = bit_q;
    dly_d   = dly_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          slt_d   = Slt_req;
          word_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        dly_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (dly_q == LAT_LAST) begin
          load    = 1'b1;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      SHIFT: begin
        if (Bit_ready) begin
          shift = 1'b1;
          if (bit_q == BIT_LAST) begin
            if (word_q == WRD_LAST) begin
              state_d = DONE;
            end else begin
              word_d  = word_q + WRD_W'(1);
              dly_d   = '0;
              state_d = (GAP_CYC == 0) ? REQ : GAP;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      GAP: begin
        if (dly_q == GAP_LAST) begin
          state_d = REQ;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  code_piso #(.WORD_W(WORD_W)) u_piso (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .load_i (load),
    .shift_i(shift),
    .data_i (slt_q ? Code1 : Code0),
    .msb_o  (msb)
  );

  // Every output is a decode of registered state; Bit_ready only feeds next-state logic.
  assign Gen_en    = (state_q == REQ);
  assign Gen_slt   = (state_q != IDLE) && slt_q;
  assign Bit_valid = (state_q == SHIFT);
  assign Bit_out   = Bit_valid && msb;
  assign Frame_sof = Bit_valid && (word_q == '0) && (bit_q == '0);
  assign Frame_eof = Bit_valid && (word_q == WRD_LAST) && (bit_q == BIT_LAST);
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_code_frame_sequencer.sv
`default_nettype none
// Bench for code_frame_sequencer: frame vectors, corner sequences and a random-ready
// stream checked against a word-queue model of the expected bit stream.
module tb_code_frame_sequencer;

  localparam int W     = 64;
  localparam int BL    = 4;
  localparam int GAPC  = 2;
  localparam int LAT   = 1;
  localparam int TOTAL = W * BL;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic         Reset = 1'b1, Start = 1'b0, Slt_req = 1'b0, Bit_ready = 1'b0;
  logic [W-1:0] Code0 = '0, Code1 = '0;
  logic         Gen_en, Gen_slt, Bit_out, Bit_valid, Frame_sof, Frame_eof, Busy, Done;

  logic         Start1 = 1'b0, Slt1 = 1'b1, Ready1 = 1'b1;
  logic [W-1:0] Code0_1 = 64'h1111_2222_3333_4444, Code1_1 = 64'hF00D_0000_1234_5679;
  logic         Gen_en1, Gen_slt1, Bit_out1, Bit_valid1, Frame_sof1, Frame_eof1, Busy1, Done1;

  code_frame_sequencer #(.WORD_W(W), .BURST_LEN(BL), .GAP_CYC(GAPC), .GEN_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Slt_req(Slt_req), .Code0(Code0), .Code1(Code1),
    .Gen_en(Gen_en), .Gen_slt(Gen_slt), .Bit_out(Bit_out), .Bit_valid(Bit_valid),
    .Bit_ready(Bit_ready), .Frame_sof(Frame_sof), .Frame_eof(Frame_eof), .Busy(Busy), .Done(Done)
  );

  code_frame_sequencer #(.WORD_W(W), .BURST_LEN(1), .GAP_CYC(0), .GEN_LAT(LAT)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start1), .Slt_req(Slt1), .Code0(Code0_1), .Code1(Code1_1),
    .Gen_en(Gen_en1), .Gen_slt(Gen_slt1), .Bit_out(Bit_out1), .Bit_valid(Bit_valid1),
    .Bit_ready(Ready1), .Frame_sof(Frame_sof1), .Frame_eof(Frame_eof1), .Busy(Busy1), .Done(Done1)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Settings written by the stimulus process, read by the monitor.
  int           ready_pct = 100;
  bit           rand_codes = 1'b0;
  logic [W-1:0] tab_c0 = '0, tab_c1 = '0;

  // Model state owned by the monitor.
  logic         fr_slt = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_words[$];
  logic [W-1:0] rx_word = '0, ew;
  int           gen_cnt = 0, bits_rx = 0, done_cnt = 0, cyc = 0, last_gen = 0;
  logic         prev_valid = 0, prev_ready = 0, prev_bit = 0, prev_sof = 0, prev_eof = 0;
  logic         prev_acc_eof = 0;

  // The bench plays the generator: each Gen_en produces new outputs, and the word the
  // frame's select picks is the next word the serial stream must carry.
  always @(negedge Clk) begin
    cyc++;
    if (Reset) begin
      exp_q.delete();
      gen_cnt = 0; bits_rx = 0; prev_valid = 0; prev_acc_eof = 0; Bit_ready = 1'b0;
    end else begin
      if (Start && !Busy) begin
        fr_slt = Slt_req;
        exp_q.delete(); rx_words.delete();
        gen_cnt = 0; bits_rx = 0;
      end
      chk("gen_slt", Gen_slt, Busy ? fr_slt : 1'b0);
      if (Gen_en) begin
        gen_cnt++;
        chk("gen_en_count_le_burst", gen_cnt <= BL, 1);
        if (ready_pct == 100 && gen_cnt > 1) chk("gen_en_spacing", cyc - last_gen, W + 1 + LAT + GAPC);
        last_gen = cyc;
        Code0 = rand_codes ? {$urandom, $urandom} : tab_c0;
        Code1 = rand_codes ? {$urandom, $urandom} : tab_c1;
        exp_q.push_back(fr_slt ? Code1 : Code0);
      end
      if (prev_valid && !prev_ready)
        chk("stall_hold", {Bit_valid, Bit_out, Frame_sof, Frame_eof}, {1'b1, prev_bit, prev_sof, prev_eof});
      if (Done) begin
        done_cnt++;
        chk("done_bits", bits_rx, TOTAL);
        chk("done_after_eof", prev_acc_eof, 1);
        chk("done_gen_pulses", gen_cnt, BL);
      end
      Bit_ready = ($urandom_range(99) < ready_pct);
      prev_acc_eof = 1'b0;
      if (Bit_valid && Bit_ready) begin
        if (bits_rx / W < exp_q.size()) ew = exp_q[bits_rx / W];
        else ew = 'x;
        chk("bit_data", Bit_out, ew[W-1-(bits_rx % W)]);
        chk("sof", Frame_sof, bits_rx == 0);
        chk("eof", Frame_eof, bits_rx == TOTAL - 1);
        rx_word = {rx_word[W-2:0], Bit_out};
        bits_rx++;
        if (bits_rx % W == 0) rx_words.push_back(rx_word);
        prev_acc_eof = Frame_eof;
      end
      prev_valid = Bit_valid; prev_ready = Bit_ready; prev_bit = Bit_out;
      prev_sof = Frame_sof; prev_eof = Frame_eof;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(input logic slt, input logic [W-1:0] c0, input logic [W-1:0] c1,
                           input int pct, input bit rnd, input bit noise);
    int n, d0;
    tab_c0 = c0; tab_c1 = c1; ready_pct = pct; rand_codes = rnd;
    d0 = done_cnt;
    Slt_req = slt; Start = 1'b1;
    tick(); Start = 1'b0;
    chk("lat_cycle1", {Gen_en, Bit_valid, Busy, Gen_slt}, {1'b1, 1'b0, 1'b1, slt});
    tick();
    chk("lat_cycle2", {Gen_en, Bit_valid}, 2'b00);
    tick();
    chk("lat_first_bit", {Bit_valid, Frame_sof}, 2'b11);
    n = 0;
    while (!Done && n < 5000) begin
      if (noise) begin
        Start   = ($urandom_range(9) == 0);
        Slt_req = $urandom_range(1);
      end
      tick(); n++;
    end
    chk("done_seen", Done, 1);
    Start = noise; Slt_req = noise ? ~slt : slt;
    tick(); Start = 1'b0;
    chk("busy_after_done", {Busy, Done, Gen_en}, 3'b000);
    repeat (4) tick();
    chk("idle_stays", {Busy, Gen_en}, 2'b00);
    chk("done_once", done_cnt - d0, 1);
    chk("word_count", rx_words.size(), BL);
  endtask

  typedef struct {
    logic         slt;
    logic [W-1:0] c0;
    logic [W-1:0] c1;
    int           pct;
    logic [W-1:0] exp_w;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, bits, sof_at, eof_at, dones, done_cyc, gens, d0;
    logic [W-1:0] word;

    vecs[0] = '{1'b0, 64'h8000_0000_0000_0001, 64'h7777_7777_7777_7777, 100, 64'h8000_0000_0000_0001};
    vecs[1] = '{1'b1, 64'h0000_0000_0000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 100, 64'hA5A5_A5A5_A5A5_A5A5};
    vecs[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 30,  64'h0123_4567_89AB_CDEF};
    vecs[3] = '{1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'h1111_1111_1111_1111, 60,  64'hDEAD_BEEF_CAFE_F00D};

    repeat (3) tick();
    Reset = 1'b0;
    chk("reset_state", {Gen_en, Gen_slt, Bit_out, Bit_valid, Frame_sof, Frame_eof, Busy, Done}, 8'h00);
    chk("reset_state_dut1", {Gen_en1, Bit_valid1, Busy1, Done1}, 4'h0);

    foreach (vecs[i]) begin
      run_frame(vecs[i].slt, vecs[i].c0, vecs[i].c1, vecs[i].pct, 1'b0, 1'b0);
      foreach (rx_words[k]) chk("vec_word", rx_words[k], vecs[i].exp_w);
    end

    // Start pulses and select changes while busy, including the DONE cycle.
    run_frame(1'b1, '0, '0, 100, 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) run_frame(1'($urandom_range(1)), '0, '0, 30, 1'b1, 1'b0);

    // Abort mid-frame with reset.
    tab_c0 = 64'hCAFE_0000_0000_BEEF; ready_pct = 100; rand_codes = 1'b0;
    Slt_req = 1'b0; Start = 1'b1;
    tick(); Start = 1'b0;
    n = 0;
    while (bits_rx < 99 && n < 500) begin tick(); n++; end
    chk("reached_bit100", bits_rx, 99);
    d0 = done_cnt;
    Reset = 1'b1;
    tick(); Reset = 1'b0;
    chk("abort_outputs", {Gen_en, Gen_slt, Bit_out, Bit_valid, Frame_sof, Frame_eof, Busy, Done}, 8'h00);
    repeat (5) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    run_frame(1'b0, 64'h0F0F_1234_8765_F0F0, '0, 100, 1'b0, 1'b0);
    foreach (rx_words[k]) chk("post_abort_word", rx_words[k], 64'h0F0F_1234_8765_F0F0);

    // Single word, no gap configuration.
    Start1 = 1'b1;
    tick(); Start1 = 1'b0;
    n = 1; bits = 0; sof_at = -1; eof_at = -1; dones = 0; done_cyc = -1; gens = 0; word = '0;
    while (n < 80) begin
      if (Gen_en1) gens++;
      if (Bit_valid1) begin
        word = {word[W-2:0], Bit_out1};
        bits++;
        if (Frame_sof1) sof_at = bits;
        if (Frame_eof1) eof_at = bits;
      end
      if (Done1) begin dones++; done_cyc = n; end
      tick(); n++;
    end
    chk("single_bits", bits, 64);
    chk("single_word", word, 64'hF00D_0000_1234_5679);
    chk("single_sof_bit", sof_at, 1);
    chk("single_eof_bit", eof_at, 64);
    chk("single_done_count", dones, 1);
    chk("single_done_cycle", done_cyc, 2 + LAT + 64);
    chk("single_gen_pulses", gens, 1);
    chk("single_idle", Busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/code_frame_sequencer.md
Name: code_frame_sequencer

Overview:
- Sequences the 64-bit dual-output code generator: pulses its enable, holds its select, captures the chosen code word (Output0 or Output1) and serializes it MSB-first to a valid/ready bit stream.
- One frame is BURST_LEN code words separated by GAP_CYC idle cycles, with start-of-frame, end-of-frame and done indications.
- Sits between the code generator and the modulator/transmit path.

Parameters:
- WORD_W, 64, code word width; must equal the generator output width.
- BURST_LEN, 4, code words per frame; must be at least 1.
- GAP_CYC, 2, idle cycles between words in a frame; 0 is legal.
- GEN_LAT, 1, cycles from the Gen_en pulse until the generator outputs are valid; must be at least 1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  frame request, sampled in IDLE only.
- Slt_req  in  1  code select for the frame; 0 selects Code0, 1 selects Code1.
- Code0  in  WORD_W  generator Output0.
- Code1  in  WORD_W  generator Output1.
- Gen_en  out  1  generator enable (drives En).
- Gen_slt  out  1  generator select (drives Slt).
- Bit_out  out  1  serial data bit.
- Bit_valid  out  1  Bit_out is valid.
- Bit_ready  in  1  downstream accepts the bit.
- Frame_sof  out  1  high with the first bit of the frame.
- Frame_eof  out  1  high with the last bit of the frame.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Clocking: one clock domain (Clk). Reset is synchronous and active-high. Reset forces state IDLE and clears every output, the shift register and all counters to 0. Reset wins over all other inputs, including mid-frame; no Done is generated for an aborted frame.
- IDLE:
  - Start=1 latches slt_r<=Slt_req, clears word_cnt, and moves to REQ.
  - Start while not in IDLE is ignored; it is not queued.
- REQ: one cycle, Gen_en=1, then WAIT.
- WAIT: GEN_LAT cycles. On the clock edge ending the last WAIT cycle:
  - sh <= slt_r ? Code1 : Code0;
  - bit_cnt <= 0;
  - move to SHIFT.
- SHIFT:
  - Bit_valid=1 and Bit_out=sh[WORD_W-1].
  - On Bit_valid && Bit_ready: sh shifts left by 1 and bit_cnt increments.
  - With Bit_ready=0, Bit_out and all flags hold stable.
  - On acceptance of bit WORD_W-1: if word_cnt==BURST_LEN-1, go to DONE. Otherwise increment word_cnt and go to GAP, or directly to REQ when GAP_CYC=0.
- GAP: GAP_CYC cycles with Bit_valid=0, then REQ.
- DONE: one cycle with Done=1, then IDLE. Start in the DONE cycle is ignored.
- Gen_slt equals slt_r from the cycle after Start until return to IDLE; it is 0 in IDLE. Gen_en is high only in REQ cycles, exactly BURST_LEN pulses per frame.
- Frame_sof = SHIFT && word_cnt==0 && bit_cnt==0.
- Frame_eof = SHIFT && word_cnt==BURST_LEN-1 && bit_cnt==WORD_W-1.
- Both flags are qualified only by state and counters, so they hold while the bit is stalled.
- Latency, all cycles stall-free: Start sampled at cycle 0, Gen_en at cycle 1, first Bit_valid at cycle 2+GEN_LAT.
- Word period is WORD_W+1+GEN_LAT+GAP_CYC cycles.
- Counters: bit_cnt is ceil(log2(WORD_W)) bits wide and word_cnt is ceil(log2(BURST_LEN)) bits wide (min 1); neither wraps beyond its terminal value.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs. Bit_ready is used only in next-state logic.

Decomposition:
- Shared package code_pkg: state enum {IDLE, REQ, WAIT, SHIFT, GAP, DONE} and the WORD_W default constant, shared with the generator.
- One natural sub-module, code_piso: a WORD_W parallel-load, shift-left serializer with load/shift enables. The FSM and counters stay in the top module.

Test Plan:
- Reset, then Start=1 with Slt_req=0 and Code0=64'h8000_0000_0000_0001, Bit_ready=1 throughout.
  - Gen_en high at cycle 1, first Bit_valid at cycle 3.
  - Bits received are 1, sixty-two 0s, then 1; Frame_sof on the first bit.
- Slt_req=1, Code1=64'hA5A5_A5A5_A5A5_A5A5, BURST_LEN=4, GAP_CYC=2.
  - Gen_slt=1 for the whole frame; 4 Gen_en pulses spaced 68 cycles apart.
  - 256 bits received, 2-cycle gaps between words.
  - Frame_eof on bit 256; Done 1 cycle later; Busy drops the cycle after Done.
- Random Bit_ready at 30% duty.
  - Bit_out stable whenever Bit_valid=1 and Bit_ready=0.
  - Received stream equals the captured words; word count is exactly 4.
- Start pulsed during SHIFT and during DONE.
  - No extra Gen_en pulse, no second frame; Slt_req changes mid-frame do not alter Gen_slt.
- Reset asserted at bit 100 of a frame.
  - The next cycle shows IDLE with all outputs 0 and no Done.
  - A following Start produces a clean frame beginning with Frame_sof.
- GAP_CYC=0, BURST_LEN=1.
  - Single word of 64 bits, no GAP state visited.
  - Frame_sof and Frame_eof fall on bits 1 and 64 respectively; one Done pulse.
